round_pipe: RTL and testbench



---
 rtl/round_pipe.sv | 101 ++++++++++
 tb/tb_round_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
// Two-stage rounding unit: narrows an IN_W-bit magnitude to OUT_W bits under RNE/RZ/RDN/RUP,
// with carry-correct increment, optional saturation, per-beat and sticky flags, valid/ready flow.
module round_pipe #(
    parameter int IN_W  = 38,
    parameter int OUT_W = 19,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sign,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_inexact,
    output logic             out_ovf,
    input  logic             flag_clr,
    output logic             flag_inexact_acc,
    output logic             flag_ovf_acc
);
    localparam int D = IN_W - OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] trunc;
        logic             inc;
        logic             inexact;
    } s1_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             inexact;
        logic             ovf;
    } s2_t;

    logic [2:1]   vld_pipe;
    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic         s1_adv, s2_adv;
    logic         g, s;
    logic [OUT_W:0] sum;

    assign s2_adv   = ~vld_pipe[2] | out_ready;
    assign s1_adv   = ~vld_pipe[1] | s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        g             = in_data[D-1];
        s             = |in_data[D-2:0];
        s1_d.trunc    = in_data[IN_W-1:D];
        s1_d.inexact  = g | s;
        s1_d.inc      = 1'b0;
        unique case (in_mode)
            2'b00: s1_d.inc = g & (s | s1_d.trunc[0]);
            2'b01: s1_d.inc = 1'b0;
            2'b10: s1_d.inc = in_sign & (g | s);
            2'b11: s1_d.inc = ~in_sign & (g | s);
            default: s1_d.inc = 1'b0;
        endcase
    end

    // The extra top bit of sum catches the carry out of an all-ones trunc.
    always_comb begin
        sum          = {1'b0, s1_q.trunc} + {{OUT_W{1'b0}}, s1_q.inc};
        s2_d.ovf     = sum[OUT_W];
        s2_d.inexact = s1_q.inexact;
        s2_d.data    = (SAT && sum[OUT_W]) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid)    s1_q <= s1_d;
        if (s2_adv && vld_pipe[1]) s2_q <= s2_d;
    end

    // A clear and a set in the same cycle leave the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_inexact_acc <= 1'b0;
            flag_ovf_acc     <= 1'b0;
        end else begin
            flag_inexact_acc <= (flag_inexact_acc & ~flag_clr) | (out_valid & out_ready & s2_q.inexact);
            flag_ovf_acc     <= (flag_ovf_acc & ~flag_clr)     | (out_valid & out_ready & s2_q.ovf);
        end
    end

    assign out_valid   = vld_pipe[2];
    assign out_data    = s2_q.data;
    assign out_inexact = s2_q.inexact;
    assign out_ovf     = s2_q.ovf;
endmodule

// File: tb/tb_round_pipe.sv
// Bench for round_pipe: directed rounding/flow/flag/reset steps plus random traffic, scored
// against an arithmetic rounding model; a second SAT=0 instance shares the same inputs.
module tb_round_pipe;
    localparam int IN_W  = 38;
    localparam int OUT_W = 19;
    localparam int D     = IN_W - OUT_W;

    logic             clk = 1'b0, reset_n = 1'b0;
    logic             in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0, flag_clr = 1'b0;
    logic [1:0]       in_mode = 2'b00;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready, out_valid, out_inexact, out_ovf, fi, fo;
    logic [OUT_W-1:0] out_data;
    logic             in_ready0, out_valid0, out_inexact0, out_ovf0, fi0, fo0;
    logic [OUT_W-1:0] out_data0;

    int checks = 0, errors = 0;

    typedef struct { logic [IN_W-1:0] d; logic s; logic [1:0] m; } beat_t;
    typedef struct { logic [OUT_W-1:0] d1, d0; logic inex, ovf; } exp_t;

    beat_t pend[$];
    exp_t  sb[$];
    logic  m_fi = 1'b0, m_fo = 1'b0;
    bit    accepted;
    int    nacc;

    round_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sign(in_sign), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inexact(out_inexact), .out_ovf(out_ovf), .flag_clr(flag_clr),
        .flag_inexact_acc(fi), .flag_ovf_acc(fo));

    round_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_sign(in_sign), .in_mode(in_mode),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_inexact(out_inexact0), .out_ovf(out_ovf0), .flag_clr(flag_clr),
        .flag_inexact_acc(fi0), .flag_ovf_acc(fo0));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Rounding as arithmetic on quotient and remainder of in_data / 2^D.
    function automatic exp_t model(beat_t b);
        exp_t e;
        longint unsigned q, rem, half, lim, r;
        bit inc;
        q    = 64'(b.d) >> D;
        rem  = 64'(b.d) % (64'd1 << D);
        half = 64'd1 << (D - 1);
        lim  = 64'd1 << OUT_W;
        case (b.m)
            2'b00:   inc = (rem > half) || (rem == half && (q % 2) == 1);
            2'b01:   inc = 1'b0;
            2'b10:   inc = b.s && rem != 0;
            default: inc = !b.s && rem != 0;
        endcase
        r      = q + 64'(inc);
        e.inex = rem != 0;
        e.ovf  = r >= lim;
        e.d1   = e.ovf ? OUT_W'(lim - 1) : OUT_W'(r);
        e.d0   = OUT_W'(r % lim);
        return e;
    endfunction

    function automatic logic [IN_W-1:0] mk(logic [OUT_W-1:0] t, logic g, logic s);
        logic [D-2:0] low;
        low = s ? (D-1)'($urandom_range(1, (1 << (D - 1)) - 1)) : '0;
        return {t, g, low};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(logic [OUT_W-1:0] t, logic g, logic s, logic sg, logic [1:0] m);
        beat_t b;
        b.d = mk(t, g, s); b.s = sg; b.m = m;
        pend.push_back(b);
    endtask

    // Called at a falling edge with inputs already driven; scores this cycle, then advances one.
    task automatic tick();
        exp_t  e;
        beat_t b;
        bit    xo, xi, clr, got;
        #1;
        chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
        xo  = out_valid && out_ready;
        xi  = in_valid && in_ready;
        clr = flag_clr;
        got = 1'b0;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                e   = sb[0];
                got = 1'b1;
                chk("out_data", out_data, e.d1);
                chk("out_inexact", out_inexact, e.inex);
                chk("out_ovf", out_ovf, e.ovf);
                chk("out_data_wrap", out_data0, e.d0);
                if (xo) void'(sb.pop_front());
            end
        end
        if (xi) begin
            b.d = in_data; b.s = in_sign; b.m = in_mode;
            sb.push_back(model(b));
        end
        if (clr) begin m_fi = 1'b0; m_fo = 1'b0; end
        if (xo && got) begin m_fi = m_fi | e.inex; m_fo = m_fo | e.ovf; end
        accepted = xi;
        @(negedge clk);
        chk("flag_inexact_acc", fi, m_fi);
        chk("flag_ovf_acc", fo, m_fo);
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: ready low for cycles 0-4, then high.
    task automatic stream(int mode, int maxcyc);
        int cyc;
        cyc  = 0;
        nacc = 0;
        while ((pend.size() > 0 || sb.size() > 0) && cyc < maxcyc) begin
            in_valid = pend.size() > 0 && (mode != 1 || $urandom_range(3) != 0);
            if (pend.size() > 0) begin
                in_data = pend[0].d; in_sign = pend[0].s; in_mode = pend[0].m;
            end
            out_ready = (mode == 2) ? (cyc >= 5) : (mode == 1) ? ($urandom_range(2) != 0) : 1'b1;
            tick();
            if (accepted) begin void'(pend.pop_front()); nacc++; end
            if (mode == 2 && cyc == 4) chk("bp_accepted_while_stalled", nacc, 2);
            cyc++;
        end
        chk("drain_done", pend.size() + sb.size(), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [OUT_W-1:0] t;
        logic [D-1:0]     rem;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flag_inexact", fi, 0);
        chk("rst_flag_ovf", fo, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // Latency: beat presented in the cycle starting at edge N shows after edge N+2.
        in_valid = 1'b1; in_data = mk(19'h00005, 1'b1, 1'b0); in_mode = 2'b00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_after_1_edge", out_valid, 0);
        tick();
        chk("lat_after_2_edges", out_valid, 1);
        tick();

        // RNE ties and rounding
        add(19'h00004, 1, 0, 0, 2'b00);
        add(19'h00005, 1, 0, 0, 2'b00);
        add(19'h00004, 0, 1, 0, 2'b00);
        add(19'h00123, 0, 0, 0, 2'b00);
        // Directed modes on trunc=3, G=0, S=1
        add(19'h00003, 0, 1, 0, 2'b01);
        add(19'h00003, 0, 1, 0, 2'b11);
        add(19'h00003, 0, 1, 1, 2'b11);
        add(19'h00003, 0, 1, 1, 2'b10);
        add(19'h00003, 0, 1, 0, 2'b10);
        stream(0, 100);

        // Overflow: saturate on the SAT=1 unit, wrap to zero on the SAT=0 unit
        add(19'h7FFFF, 1, 1, 0, 2'b00);
        stream(0, 50);
        chk("ovf_sticky", fo, 1);

        // Backpressure: 5 beats, output stalled for the first 5 cycles
        for (int i = 0; i < 5; i++)
            add(19'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        stream(2, 100);

        // Flags: clear with a held inexact beat at the output, then clear coinciding with its transfer
        in_valid = 1'b1; in_data = mk(19'h00004, 1'b1, 1'b0); in_mode = 2'b00; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        flag_clr = 1'b1;
        tick();
        chk("clr_inexact", fi, 0);
        chk("clr_ovf", fo, 0);
        out_ready = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_set_wins", fi, 1);

        // Reset with 2 beats in flight
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(19'h00010, 1'b1, 1'b1); in_mode = 2'b01;
        tick();
        in_data = mk(19'h00020, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_flag", fi, 0);
        sb.delete();
        m_fi = 1'b0; m_fo = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("post_rst_no_stale", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);

        // Random traffic, biased toward guard/sticky boundaries and carry-out
        for (int i = 0; i < 300; i++) begin
            beat_t b;
            t = ($urandom_range(4) == 0) ? 19'h7FFFF : 19'($urandom);
            case ($urandom_range(4))
                0: rem = '0;
                1: rem = 19'h40000;
                2: rem = 19'h40001;
                3: rem = 19'h3FFFF;
                default: rem = 19'($urandom);
            endcase
            b.d = {t, rem}; b.s = 1'($urandom); b.m = 2'($urandom);
            pend.push_back(b);
        end
        stream(1, 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
